// File: rtl/tristate_bus_reader_pkg.sv
// Shared definitions for the tri-state bus reader.
//   - FSM state encodings (IDLE, DRIVE, RESP)
//   - width of the settle down-counter
//   - CS_RELEASED: all-ones chip-select pattern (bus released), sliced to
//     the instance width by the users
package tristate_bus_reader_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam int SettleBits = 4;

  localparam int MaxSlaves = 256;
  localparam logic [MaxSlaves-1:0] CS_RELEASED = '1;

endpackage

// File: rtl/tristate_bus_reader_cs_decoder.sv
// Combinational active-low one-hot chip-select decoder.
// Ports:
//   idx_i      slave index
//   en_i       decode enable
//   in_range_i index is below NrOfSlaves
//   cs_n_o     one-hot-low selects; all ones when disabled or out of range
module cs_onehot_decoder
  import tristate_bus_reader_pkg::*;
#(
  parameter int NrOfSlaves = 8,
  parameter int AddrBits   = 3
) (
  input  logic [AddrBits-1:0]   idx_i,
  input  logic                  en_i,
  input  logic                  in_range_i,
  output logic [NrOfSlaves-1:0] cs_n_o
);

  always_comb begin
    cs_n_o = CS_RELEASED[NrOfSlaves-1:0];
    if (en_i && in_range_i) begin
      for (int i = 0; i < NrOfSlaves; i++) begin
        if (idx_i == AddrBits'(i)) cs_n_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/tristate_bus_reader.sv
// Reader for the shared tri-state data bus. Accepts a slave index, pulls
// exactly one chip select low, waits SettleCycles extra Tick cycles, captures
// the bus, releases the select and presents the value on a valid/ready port.
// Ports:
//   Clock, Reset           clock, async active-high reset
//   Tick                   clock enable for all state
//   req_valid/ready/addr   read request
//   bus_data               shared bus, sampled at capture
//   cs_n                   one-hot-low chip selects (all ones = released)
//   rsp_valid/ready        response handshake
//   rsp_data/addr/err      captured data, slave index, index-out-of-range flag
module tristate_bus_reader
  import tristate_bus_reader_pkg::*;
#(
  parameter int NrOfBits     = 32,
  parameter int NrOfSlaves   = 8,   // 2..256
  parameter int AddrBits     = 3,   // 2**AddrBits >= NrOfSlaves
  parameter int SettleCycles = 1    // 0..15
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Tick,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [AddrBits-1:0]   req_addr,
  input  logic [NrOfBits-1:0]   bus_data,
  output logic [NrOfSlaves-1:0] cs_n,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [NrOfBits-1:0]   rsp_data,
  output logic [AddrBits-1:0]   rsp_addr,
  output logic                  rsp_err
);

  localparam logic [NrOfSlaves-1:0] CsIdle = CS_RELEASED[NrOfSlaves-1:0];

  logic [1:0]            state_q, state_d;
  logic [SettleBits-1:0] cnt_q, cnt_d;
  logic [AddrBits-1:0]   addr_q, addr_d;
  logic [NrOfSlaves-1:0] cs_n_q, cs_n_d;
  logic                  ready_q, ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [NrOfBits-1:0]   rsp_data_q, rsp_data_d;
  logic [AddrBits-1:0]   rsp_addr_q, rsp_addr_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  in_range;
  logic                  accept;
  logic [NrOfSlaves-1:0] cs_dec;

  assign in_range = 32'(req_addr) < 32'(NrOfSlaves);
  assign accept   = Tick && req_valid && (state_q == IDLE);

  cs_onehot_decoder #(
    .NrOfSlaves(NrOfSlaves),
    .AddrBits  (AddrBits)
  ) u_dec (
    .idx_i     (req_addr),
    .en_i      (accept),
    .in_range_i(in_range),
    .cs_n_o    (cs_dec)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    cs_n_d      = cs_n_q;
    ready_d     = ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_err_d   = rsp_err_q;
    if (Tick) begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_d  = req_addr;
            cnt_d   = SettleBits'(SettleCycles);
            ready_d = 1'b0;
            cs_n_d  = cs_dec;  // stays all ones for an out-of-range index
            if (in_range) begin
              state_d = DRIVE;
            end else begin
              rsp_data_d  = '0;
              rsp_addr_d  = req_addr;
              rsp_err_d   = 1'b1;
              rsp_valid_d = 1'b1;
              state_d     = RESP;
            end
          end
        end
        DRIVE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - SettleBits'(1);
          end else begin
            rsp_data_d  = bus_data;
            rsp_addr_d  = addr_q;
            rsp_err_d   = 1'b0;
            rsp_valid_d = 1'b1;
            cs_n_d      = CsIdle;
            state_d     = RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            ready_d     = 1'b1;
            state_d     = IDLE;
          end
        end
        default: begin
          cs_n_d      = CsIdle;
          ready_d     = 1'b1;
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      cs_n_q      <= CsIdle;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      cs_n_q      <= cs_n_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = ready_q;
  assign cs_n      = cs_n_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_err   = rsp_err_q;

endmodule
